// File: rtl/fnd_pkg.sv
// Shared types and constants for the seven-segment digit scan controller.
package fnd_pkg;

    // Width of the digit-select index driven to the BCD mux.
    localparam int FND_DIGIT_W = 2;

    // All commons released (active-low commons, so every digit dark).
    localparam logic [3:0] FND_COM_OFF = 4'b1111;

    // Scan controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } fnd_state_e;

    // Active-low common pattern that lights exactly one digit.
    function automatic logic [3:0] fnd_com_for(input logic [FND_DIGIT_W-1:0] digit);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << digit;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// Modulo-TERM counter with synchronous clear and a terminal-count pulse.
// o_tc is high in the last enabled cycle of each TERM-cycle period; the
// count wraps to zero on the same edge.
module fnd_tick_gen #(
    parameter int unsigned TERM = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int W = (TERM > 1) ? $clog2(TERM) : 1;
    localparam logic [W-1:0] LAST = W'(TERM - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance and wrap at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = i_en & ~i_clr & (cnt_q == LAST);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed seven-segment digit scanner.
// Build option FND_GHOST_BLANK_EN: when defined, an all-off BLANK gap of
// BLANK_CYCLES is inserted before every digit to suppress ghosting; when
// undefined, digits are driven back to back for SCAN_DIV cycles each.
import fnd_pkg::*;

module fnd_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned NUM_DIGITS   = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    output logic [FND_DIGIT_W-1:0] o_counter_Mux,
    output logic [3:0]             o_fnd_com,
    output logic                   o_digit_tick
);

    localparam logic [FND_DIGIT_W-1:0] LAST_DIGIT = FND_DIGIT_W'(NUM_DIGITS - 1);

    logic                   rst_sync_q;
    logic                   rst_n_s;
    fnd_state_e             state_q, state_d;
    logic [FND_DIGIT_W-1:0] digit_q, digit_d;
    logic [3:0]             com_q, com_d;
    logic                   tick_q, tick_d;
    logic                   drive_tc_s;
    logic                   blank_tc_s;

    // Reset synchronizer: asserts asynchronously, releases on a clock edge,
    // so the FSM makes its first move one edge after i_rst_n rises.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    assign rst_n_s = rst_sync_q;

    fnd_tick_gen #(
        .TERM (SCAN_DIV)
    ) u_drive_cnt (
        .i_clk   (i_clk),
        .i_rst_n (rst_n_s),
        .i_clr   ((state_q != ST_DRIVE) | ~i_enable),
        .i_en    (state_q == ST_DRIVE),
        .o_tc    (drive_tc_s)
    );

`ifdef FND_GHOST_BLANK_EN
    fnd_tick_gen #(
        .TERM (BLANK_CYCLES)
    ) u_blank_cnt (
        .i_clk   (i_clk),
        .i_rst_n (rst_n_s),
        .i_clr   ((state_q != ST_BLANK) | ~i_enable),
        .i_en    (state_q == ST_BLANK),
        .o_tc    (blank_tc_s)
    );
`else
    // No blank gap in this build: BLANK is unreachable and would leave at once.
    logic [31:0] unused_blank_cycles_s;
    assign unused_blank_cycles_s = 32'(BLANK_CYCLES);
    assign blank_tc_s = 1'b1;
`endif

    // Next state, next digit, tick and the commons pattern of the next state.
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        tick_d  = 1'b0;
        if (!i_enable) begin
            state_d = ST_IDLE;
            digit_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    digit_d = '0;
`ifdef FND_GHOST_BLANK_EN
                    state_d = ST_BLANK;
`else
                    state_d = ST_DRIVE;
`endif
                end
                ST_BLANK: begin
                    if (blank_tc_s) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end
                ST_DRIVE: begin
                    if (drive_tc_s) begin
                        tick_d  = 1'b1;
                        digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + FND_DIGIT_W'(1);
`ifdef FND_GHOST_BLANK_EN
                        state_d = ST_BLANK;
`else
                        state_d = ST_DRIVE;
`endif
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    digit_d = '0;
                end
            endcase
        end
        if (state_d == ST_DRIVE) begin
            com_d = fnd_com_for(digit_d);
        end else begin
            com_d = FND_COM_OFF;
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q <= ST_IDLE;
            digit_q <= '0;
            com_q   <= FND_COM_OFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            com_q   <= com_d;
            tick_q  <= tick_d;
        end
    end

    assign o_counter_Mux = digit_q;
    assign o_fnd_com     = com_q;
    assign o_digit_tick  = tick_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl (SCAN_DIV=4, BLANK_CYCLES=2) with a
// 2-digit and a 4-digit instance driven from the same inputs. Build with or
// without FND_GHOST_BLANK_EN; the reference model follows the same macro.
module tb_fnd_scan_ctrl;

    localparam int S = 4;
    localparam int B = 2;
`ifdef FND_GHOST_BLANK_EN
    localparam int P = B + S;
`else
    localparam int P = S;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mux2, mux4;
    logic [3:0] com2, com4;
    logic       tick2, tick4;

    int n_vec = 0;
    int n_err = 0;
    int act = -1;     // cycles since scanning started; -1 means idle
    bit armed = 1'b0; // one edge has passed since reset release

    fnd_scan_ctrl #(.SCAN_DIV(S), .BLANK_CYCLES(B), .NUM_DIGITS(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
        .o_counter_Mux(mux2), .o_fnd_com(com2), .o_digit_tick(tick2)
    );

    fnd_scan_ctrl #(.SCAN_DIV(S), .BLANK_CYCLES(B), .NUM_DIGITS(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
        .o_counter_Mux(mux4), .o_fnd_com(com4), .o_digit_tick(tick4)
    );

    always #5 clk = ~clk;

    // Expected digit for a given active-cycle count.
    function automatic logic [1:0] exp_mux(input int a, input int n);
        if (a < 0) return 2'd0;
        return 2'((a / P) % n);
    endfunction

    // Position inside the DRIVE part of a digit slot, -1 while blanked.
    function automatic int drive_pos(input int a);
        if (a < 0) return -1;
`ifdef FND_GHOST_BLANK_EN
        if ((a % P) < B) return -1;
        return (a % P) - B;
`else
        return a % P;
`endif
    endfunction

    function automatic logic [3:0] exp_com(input int a, input int n);
        logic [3:0] one;
        logic [1:0] d;
        if (drive_pos(a) < 0) return 4'b1111;
        d   = exp_mux(a, n);
        one = 4'b0001 << d;
        return ~one;
    endfunction

    function automatic logic exp_tick(input int a);
        return (a > 0) && ((a % P) == 0);
    endfunction

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: counts active cycles from the spec's timing rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act = -1;
            armed = 1'b0;
        end else if (!armed) begin
            armed = 1'b1;
            act = -1;
        end else if (!en) begin
            act = -1;
        end else begin
            act = act + 1;
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("com2",  com2,             exp_com(act, 2));
        chk("mux2",  {2'b00, mux2},    {2'b00, exp_mux(act, 2)});
        chk("tick2", {3'b000, tick2},  {3'b000, exp_tick(act)});
        chk("com4",  com4,             exp_com(act, 4));
        chk("mux4",  {2'b00, mux4},    {2'b00, exp_mux(act, 4)});
        chk("tick4", {3'b000, tick4},  {3'b000, exp_tick(act)});
    end

    logic [3:0] start_tbl [15];
    logic [3:0] restart_tbl [3];
    int         restart_len;
    bit         found;
    bit         lit_tick;

    initial begin
`ifdef FND_GHOST_BLANK_EN
        start_tbl = '{4'b1111, 4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1110,
                      4'b1111, 4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1101,
                      4'b1111, 4'b1111};
        restart_tbl = '{4'b1111, 4'b1111, 4'b1110};
        restart_len = 3;
`else
        start_tbl = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1110,
                      4'b1101, 4'b1101, 4'b1101, 4'b1101,
                      4'b1110, 4'b1110, 4'b1110, 4'b1110,
                      4'b1101, 4'b1101};
        restart_tbl = '{4'b1110, 4'b1110, 4'b1110};
        restart_len = 1;
`endif
        #1 rst_n = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_com", com2, 4'b1111);
        chk("rst_mux", {2'b00, mux2}, 4'b0000);
        chk("rst_tick", {3'b000, tick2}, 4'b0000);
        rst_n = 1'b1;

        // Startup sequence pinned to hand-derived values.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("start_com", com2, start_tbl[i]);
`ifdef FND_GHOST_BLANK_EN
            lit_tick = (i == 7) || (i == 13);
`else
            lit_tick = (i == 5) || (i == 9) || (i == 13);
`endif
            chk("start_tick", {3'b000, tick2}, {3'b000, lit_tick});
        end

        // Drop enable in the second DRIVE cycle of digit 1.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (exp_mux(act, 2) == 2'd1 && drive_pos(act) == 1) found = 1'b1;
        end
        chk("wait_drive1", {3'b000, found}, 4'b0001);
        en = 1'b0;
        @(negedge clk);
        chk("drop_com", com2, 4'b1111);
        chk("drop_mux", {2'b00, mux2}, 4'b0000);
        en = 1'b1;
        for (int i = 0; i < restart_len; i++) begin
            @(negedge clk);
            chk("restart_com", com2, restart_tbl[i]);
            chk("restart_mux", {2'b00, mux2}, 4'b0000);
        end

        // Asynchronous reset pulse in the middle of a DRIVE cycle.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (drive_pos(act) == 2) found = 1'b1;
        end
        chk("wait_drive", {3'b000, found}, 4'b0001);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_com2", com2, 4'b1111);
        chk("arst_mux2", {2'b00, mux2}, 4'b0000);
        chk("arst_tick2", {3'b000, tick2}, 4'b0000);
        chk("arst_com4", com4, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized enable activity with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 99) < 96);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #1 chk("rnd_arst_com", com2, 4'b1111);
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000: clock cycles each digit is driven; legal range 2..2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000: all-digits-off cycles between digits; legal range 1..2^16.
REQ-003 SHALL have parameter NUM_DIGITS, default 2: digits scanned; legal range 2..4.
REQ-004 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_enable  input  1  scan enable; low blanks the display.
REQ-007 SHALL have port o_counter_Mux  output  2  digit index; drives the BCD digit-select mux (0=ones, 1=tens, ...).
REQ-008 SHALL have port o_fnd_com  output  4  active-low digit commons; bit n drives digit n.
REQ-009 SHALL have port o_digit_tick  output  1  one-cycle pulse on each digit advance.

Function
REQ-010 SHALL implement states IDLE, BLANK, DRIVE; all outputs registered.
REQ-011 IDLE: o_fnd_com=4'b1111, digit index held at 0, counters cleared; when i_enable=1, go to BLANK next cycle.
REQ-012 BLANK: o_fnd_com=4'b1111; count BLANK_CYCLES cycles, then go to DRIVE.
REQ-013 DRIVE: o_fnd_com bit o_counter_Mux low and all other bits high; count SCAN_DIV cycles.
REQ-014 At the end of DRIVE: increment o_counter_Mux (NUM_DIGITS-1 wraps to 0), pulse o_digit_tick, go to BLANK.
REQ-015 o_counter_Mux SHALL change only on entry to BLANK, never while its common is asserted.
REQ-016 Per-digit period SHALL be exactly BLANK_CYCLES+SCAN_DIV cycles; full frame is NUM_DIGITS times that.
REQ-017 i_enable=0 in any state SHALL force IDLE on the next edge; o_fnd_com=4'b1111 and o_counter_Mux=0 in that cycle; no o_digit_tick.
REQ-018 i_enable reasserted SHALL restart at digit 0 via BLANK.
REQ-019 o_fnd_com bits [3:NUM_DIGITS] SHALL be 1 at all times.
REQ-020 Counters SHALL be sized by $clog2 of their terminal value and SHALL never exceed it.

Reset
REQ-021 While i_rst_n=0: state=IDLE, o_counter_Mux=2'b00, o_fnd_com=4'b1111, o_digit_tick=0, all counters 0; takes effect asynchronously.
REQ-022 Reset deassertion SHALL be synchronized; first state change is at least one edge after release.
REQ-023 Reset mid-DRIVE SHALL blank the commons immediately, with no partial tick.

Configuration
REQ-024 Macro FND_GHOST_BLANK_EN defined: BLANK state present, per REQ-012..016.
REQ-025 Macro FND_GHOST_BLANK_EN undefined:
- BLANK state and BLANK_CYCLES are unused.
- IDLE goes straight to DRIVE.
- At the end of DRIVE, the digit advances and DRIVE continues; the commons switch to the new digit in the same cycle.
- Per-digit period is SCAN_DIV.

Structure
REQ-026 Package fnd_pkg SHALL hold the state enum type, the constant FND_COM_OFF=4'b1111, and the digit-index width of 2.
REQ-027 Sub-module fnd_tick_gen (parameterised modulo counter with clear and terminal-count pulse) SHALL be instantiated for both the DRIVE and BLANK counters.

Verification
REQ-028 Bench parameters: SCAN_DIV=4, BLANK_CYCLES=2, NUM_DIGITS=2.
REQ-029 Reset held, then released with i_enable=1:
- o_fnd_com is 1111 for 3 cycles (1 IDLE + 2 BLANK).
- Then 1110 for 4 cycles, 1111 for 2 cycles, 1101 for 4 cycles, and the pattern repeats.
REQ-030 Steady scan: o_digit_tick pulses every 6 cycles; o_counter_Mux sequence 0,1,0,1; the value never changes while its common is low.
REQ-031 i_enable dropped during the 2nd DRIVE cycle of digit 1: next edge o_fnd_com=1111 and o_counter_Mux=0; reassert restarts at digit 0 after 2 BLANK cycles.
REQ-032 i_rst_n pulsed low mid-DRIVE: o_fnd_com=1111 and o_counter_Mux=0 before the next clock edge; no o_digit_tick.
REQ-033 FND_GHOST_BLANK_EN undefined: o_fnd_com alternates 1110 and 1101 every 4 cycles with no 1111 gap; NUM_DIGITS=4 run covers wrap 3 to 0.
